lr_stack: RTL and testbench
===========================

# lr_stack

Parametrised link-register stack: the successor to the single loadable link register in the one-cycle CPU. It holds up to DEPTH return addresses so that nested CALL/RET sequences work without spilling to data memory. The top-of-stack output drives the PC mux on RET. Push and pop are single-cycle, and sticky overflow/underflow flags are provided for the control unit.

## Interface
- WIDTH, 8, bit width of each stored address
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- push  input  1  store data as new top (CALL)
- pop  input  1  discard current top (RET)
- data  input  WIDTH  value to push
- clr_err  input  1  clears ovf and unf
- out  output  WIDTH  current top-of-stack value; 0 when empty
- count  output  $clog2(DEPTH+1)  number of valid entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- ovf  output  1  sticky: push attempted while full
- unf  output  1  sticky: pop attempted while empty

## Operation
- Storage is a circular buffer of DEPTH × WIDTH registers, addressed by a top pointer `tp` of $clog2(DEPTH) bits. Pointer arithmetic is modulo DEPTH.
- Cycle actions at each rising clk, when rst = 0:
  - push only, not full: `tp` advances by 1, data is written at the new `tp`, count increments.
  - push only, full: governed by LR_STACK_WRAP_EN (see Configuration); ovf is set.
  - pop only, not empty: `tp` retreats by 1, count decrements. The entry contents are left as they are.
  - pop only, empty: no state change; unf is set.
  - push and pop, count > 0: the top is replaced by data in place; `tp` and count are unchanged; no flag is set.
  - push and pop, empty: acts as push only; unf is not set.
  - neither: hold.
- clr_err clears ovf and unf in the same cycle. If an error event occurs in the same cycle as clr_err, the flag is set, not cleared.
- out = entry[tp] when count > 0, otherwise 0. out is a combinational read of registered state, with no extra pipeline stage.
- Reset mid-operation discards all contents, regardless of push or pop in that cycle.

## Timing
- Reset values: out = 0, count = 0, empty = 1, full = 0, ovf = 0, unf = 0, `tp` = 0, all entries = 0.
- Latency:
  - A push sampled at edge N makes data visible on out immediately after edge N.
  - A pop sampled at edge N exposes the previous entry after edge N.
- count, empty, full, ovf and unf all update on the same edge as the operation that changes them.
- Back-to-back push/pop on every cycle is supported with no bubbles.
- data is sampled only on edges where push = 1.

## Configuration
- LR_STACK_WRAP_EN defined: push while full overwrites the oldest entry.
  - `tp` advances and data is written; count stays at DEPTH; ovf is set.
  - The newest DEPTH return addresses are therefore preserved.
- LR_STACK_WRAP_EN undefined: push while full is ignored.
  - Contents, `tp` and count are unchanged; ovf is set.

## Test plan
Test parameters: WIDTH = 8, DEPTH = 4.
- Reset: assert rst for 1 cycle -> out = 0x00, count = 0, empty = 1, ovf = 0, unf = 0.
- Push then pop in order: push 0x11, 0x22, 0x33, 0x44 -> full = 1, out = 0x44. Then pop ×4 -> out steps through 0x33, 0x22, 0x11, 0x00; empty = 1; no flags set.
- Overflow: from full (0x11..0x44), push 0xA7.
  - With LR_STACK_WRAP_EN: out = 0xA7, count = 4, ovf = 1; pop ×4 -> out steps through 0x44, 0x33, 0x22, then 0x00 with empty = 1.
  - Without LR_STACK_WRAP_EN: out = 0x44, ovf = 1.
- Underflow and clear: pop while empty -> unf = 1, count = 0. Assert clr_err for 1 cycle -> unf = 0. Pop and clr_err in the same cycle -> unf = 1.
- Simultaneous push and pop: with stack 0x11, 0x22, assert push + pop with data = 0x13 -> out = 0x13, count = 2; then pop -> out = 0x11. With stack empty, push + pop with data = 0x05 -> count = 1, out = 0x05, unf = 0.
- Reset mid-operation: with 3 entries, assert rst together with push of 0x55 -> count = 0, out = 0x00, empty = 1, flags = 0.

Source files
------------

// File: rtl/lr_stack.sv
// lr_stack: link-register stack holding up to DEPTH return addresses for
// nested CALL/RET. Storage is a circular buffer addressed by a top pointer.
// The top of stack is read combinationally so that RET can drive the PC mux.
// Optional feature macro: LR_STACK_WRAP_EN. When it is defined, a push while
// full overwrites the oldest entry. When it is undefined, such a push is
// ignored. In both cases ovf is set.
module lr_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Next-state decode: pointer, count, sticky flags and the single write port.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = tp_q;
    // Clearing happens first so an error event in the same cycle wins.
    ovf_d   = clr_err ? 1'b0 : ovf_q;
    unf_d   = clr_err ? 1'b0 : unf_q;
    unique case ({push, pop})
      2'b10: begin
        if (!is_full) begin
          tp_d    = tp_q + PW'(1);
          wr_en   = 1'b1;
          wr_addr = tp_q + PW'(1);
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef LR_STACK_WRAP_EN
          // Oldest entry sits just past the top, so advancing overwrites it.
          tp_d    = tp_q + PW'(1);
          wr_en   = 1'b1;
          wr_addr = tp_q + PW'(1);
`endif
        end
      end
      2'b01: begin
        if (!is_empty) begin
          tp_d    = tp_q - PW'(1);
          count_d = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Replace the top in place: a RET immediately followed by a CALL.
          wr_en   = 1'b1;
          wr_addr = tp_q;
        end else begin
          // Nothing to pop, so behave as a plain push without flagging.
          tp_d    = tp_q + PW'(1);
          wr_en   = 1'b1;
          wr_addr = tp_q + PW'(1);
          count_d = count_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Control state: pointer, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage: cleared on reset, otherwise written through the single port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= data;
    end
  end

  assign out   = is_empty ? '0 : mem_q[tp_q];
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_lr_stack.sv
// tb_lr_stack: table-driven directed checks for lr_stack (WIDTH=8, DEPTH=4).
// Each table row is one clock cycle: the inputs are applied, and the
// expected outputs are checked just after the rising edge. Overflow rows
// follow LR_STACK_WRAP_EN so the same bench serves both builds.
module tb_lr_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    count;
  logic             empty, full, ovf, unf;

  lr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .data(data),
    .clr_err(clr_err), .out(out), .count(count), .empty(empty),
    .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, push, pop, clr;
    logic [7:0] data;
    logic [7:0] e_out;
    int         e_cnt;
    logic       e_empty, e_full, e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic v(input logic r, input logic pu, input logic po, input logic c,
                   input logic [7:0] d, input logic [7:0] eo, input int ec,
                   input logic ee, input logic ef, input logic eov, input logic eun);
    vec_t x;
    x.rst = r; x.push = pu; x.pop = po; x.clr = c; x.data = d;
    x.e_out = eo; x.e_cnt = ec; x.e_empty = ee; x.e_full = ef;
    x.e_ovf = eov; x.e_unf = eun;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [7:0] eo, input int ec,
                           input logic ee, input logic ef, input logic eov, input logic eun);
    chk("out",   idx, int'(out),   int'(eo));
    chk("count", idx, int'(count), ec);
    chk("empty", idx, int'(empty), int'(ee));
    chk("full",  idx, int'(full),  int'(ef));
    chk("ovf",   idx, int'(ovf),   int'(eov));
    chk("unf",   idx, int'(unf),   int'(eun));
  endtask

  task automatic drive(input logic r, input logic pu, input logic po, input logic c,
                       input logic [7:0] d);
    @(negedge clk);
    rst = r; push = pu; pop = po; clr_err = c; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  rst pu po clr data   out  cnt emp full ovf unf
    v(1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);  // reset
    v(0, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h33, 8'h33, 3, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h44, 8'h44, 4, 0, 1, 0, 0);
    v(0, 0, 1, 0, 8'h00, 8'h33, 3, 0, 0, 0, 0);
    v(0, 0, 1, 0, 8'h00, 8'h22, 2, 0, 0, 0, 0);
    v(0, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0);
    v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1);  // underflow
    v(0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0);  // clear
    v(0, 0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1);  // pop + clear: set wins
    v(0, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    v(0, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0);
    v(0, 1, 1, 0, 8'h13, 8'h13, 2, 0, 0, 0, 0);  // replace top
    v(0, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0);
    v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    v(0, 1, 1, 0, 8'h05, 8'h05, 1, 0, 0, 0, 0);  // push+pop on empty
    v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    v(0, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h33, 8'h33, 3, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'h44, 8'h44, 4, 0, 1, 0, 0);
`ifdef LR_STACK_WRAP_EN
    v(0, 1, 0, 0, 8'hA7, 8'hA7, 4, 0, 1, 1, 0);  // overwrite oldest
    v(0, 0, 1, 0, 8'h00, 8'h44, 3, 0, 0, 1, 0);
    v(0, 0, 1, 0, 8'h00, 8'h33, 2, 0, 0, 1, 0);
    v(0, 0, 1, 0, 8'h00, 8'h22, 1, 0, 0, 1, 0);
`else
    v(0, 1, 0, 0, 8'hA7, 8'h44, 4, 0, 1, 1, 0);  // ignored
    v(0, 0, 1, 0, 8'h00, 8'h33, 3, 0, 0, 1, 0);
    v(0, 0, 1, 0, 8'h00, 8'h22, 2, 0, 0, 1, 0);
    v(0, 0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 1, 0);
`endif
    v(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 1, 0);
    v(0, 1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 1, 0);
    v(0, 1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 1, 0);
    v(0, 1, 0, 0, 8'h33, 8'h33, 3, 0, 0, 1, 0);
    v(1, 1, 0, 0, 8'h55, 8'h00, 0, 1, 0, 0, 0);  // reset beats push
    v(0, 1, 0, 0, 8'h66, 8'h66, 1, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
      check_all(i, vecs[i].e_out, vecs[i].e_cnt, vecs[i].e_empty,
                vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Idle cycles with data toggling: data must not be sampled without push.
    drive(0, 0, 0, 0, 8'hFF);
    check_all(1000, 8'h66, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 8'hC3);
    check_all(1001, 8'h66, 1, 0, 0, 0, 0);

    // Back-to-back push, replace, pop with no idle cycles in between.
    drive(0, 1, 0, 0, 8'h77);
    check_all(1002, 8'h77, 2, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 8'h78);
    check_all(1003, 8'h78, 2, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 8'h00);
    check_all(1004, 8'h66, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 8'h79);
    check_all(1005, 8'h79, 2, 0, 0, 0, 0);

    // Overflow followed by clear in the next cycle.
    drive(0, 1, 0, 0, 8'h7A);
    drive(0, 1, 0, 0, 8'h7B);
    check_all(1006, 8'h7B, 4, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 8'h7C);  // error event alongside clear: flag set
`ifdef LR_STACK_WRAP_EN
    check_all(1007, 8'h7C, 4, 0, 1, 1, 0);
`else
    check_all(1007, 8'h7B, 4, 0, 1, 1, 0);
`endif
    drive(0, 0, 0, 1, 8'h00);
    chk("ovf_clr", 1008, int'(ovf), 0);

    @(negedge clk);
    clr_err = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
